// File: rtl/snn_step_scheduler.sv
// Timestep scheduler for snn_core: per step fetches events, applies them, streams the
// captured spike row, optionally runs one STDP scan, and can sweep the learned weights out.
module snn_step_scheduler #(
    parameter int F        = 48,
    parameter int N        = 96,
    parameter int AW       = $clog2(F*N),
    parameter int EAW      = 16,
    parameter int CORE_LAT = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [15:0]         num_steps,
    input  logic                learn_en,
    input  logic                dump_en,
    output logic                busy,
    output logic                done,
    output logic [EAW-1:0]      ev_addr,
    output logic                ev_rd,
    input  logic [F-1:0]        ev_data,
    output logic [F-1:0]        core_event_vec,
    input  logic [N-1:0]        core_spikes_vec,
    output logic                stdp_enable,
    output logic [F-1:0]        stdp_pre_bits,
    output logic [N-1:0]        stdp_post_bits,
    output logic                spk_valid,
    input  logic                spk_ready,
    output logic [N-1:0]        spk_data,
    output logic [15:0]         spk_step,
    output logic [AW-1:0]       rb_addr,
    input  logic [15:0]         rb_data,
    output logic                wd_valid,
    input  logic                wd_ready,
    output logic [AW-1:0]       wd_addr,
    output logic signed [15:0]  wd_data
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_APPLY,
        S_CAPTURE,
        S_SPKOUT,
        S_LEARN,
        S_GAP,
        S_DUMP,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_WORD = AW'(F*N - 1);
    localparam logic [AW-1:0] LAT_LAST  = AW'(CORE_LAT - 1);

    state_t          state_q;
    logic [15:0]     t_q;
    logic [15:0]     steps_q;
    logic            learn_q;
    logic            dump_q;
    logic [AW-1:0]   scan_q;
    logic            busy_q;
    logic            done_q;
    logic [EAW-1:0]  ev_addr_q;
    logic            ev_rd_q;
    logic [F-1:0]    core_event_vec_q;
    logic            stdp_enable_q;
    logic [F-1:0]    stdp_pre_q;
    logic [N-1:0]    stdp_post_q;
    logic            spk_valid_q;
    logic [N-1:0]    spk_data_q;
    logic [15:0]     spk_step_q;
    logic            wd_valid_q;
    logic [AW-1:0]   wd_addr_q;

    logic [15:0]     t_inc_d;
    logic            more_steps_d;
    logic            step_end_d;
    logic            wd_hs_d;
    logic [AW-1:0]   rb_addr_d;

    assign t_inc_d      = t_q + 16'd1;
    assign more_steps_d = ({1'b0, t_q} + 17'd1) < {1'b0, steps_q};
    assign step_end_d   = ((state_q == S_SPKOUT) && spk_ready && !learn_q) || (state_q == S_GAP);
    assign wd_hs_d      = (state_q == S_DUMP) && wd_valid_q && wd_ready;

    // The readback RAM has one clock of latency, so the address steps forward in the
    // same cycle as the handshake; that keeps one word per clock with no prefetch.
    assign rb_addr_d = (wd_hs_d && (wd_addr_q != LAST_WORD)) ? wd_addr_q + 1'b1 : wd_addr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= S_IDLE;
            t_q              <= '0;
            steps_q          <= '0;
            learn_q          <= 1'b0;
            dump_q           <= 1'b0;
            scan_q           <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            ev_addr_q        <= '0;
            ev_rd_q          <= 1'b0;
            core_event_vec_q <= '0;
            stdp_enable_q    <= 1'b0;
            stdp_pre_q       <= '0;
            stdp_post_q      <= '0;
            spk_valid_q      <= 1'b0;
            spk_data_q       <= '0;
            spk_step_q       <= '0;
            wd_valid_q       <= 1'b0;
            wd_addr_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        steps_q <= num_steps;
                        learn_q <= learn_en;
                        dump_q  <= dump_en;
                        t_q     <= '0;
                        if (num_steps != 16'd0) begin
                            busy_q    <= 1'b1;
                            ev_addr_q <= '0;
                            ev_rd_q   <= 1'b1;
                            state_q   <= S_FETCH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    ev_rd_q <= 1'b0;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    core_event_vec_q <= ev_data;
                    scan_q           <= '0;
                    state_q          <= S_APPLY;
                end
                S_APPLY: begin
                    if (scan_q == LAT_LAST) begin
                        scan_q  <= '0;
                        state_q <= S_CAPTURE;
                    end else begin
                        scan_q <= scan_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    spk_data_q  <= core_spikes_vec;
                    spk_step_q  <= t_q;
                    spk_valid_q <= 1'b1;
                    state_q     <= S_SPKOUT;
                end
                S_SPKOUT: begin
                    // Pre/post bits go out only with the scan, never while a row is pending.
                    if (spk_ready) begin
                        spk_valid_q <= 1'b0;
                        if (learn_q) begin
                            stdp_enable_q <= 1'b1;
                            stdp_pre_q    <= core_event_vec_q;
                            stdp_post_q   <= spk_data_q;
                            scan_q        <= '0;
                            state_q       <= S_LEARN;
                        end
                    end
                end
                S_LEARN: begin
                    if (scan_q == LAST_WORD) begin
                        stdp_enable_q <= 1'b0;
                        stdp_pre_q    <= '0;
                        stdp_post_q   <= '0;
                        scan_q        <= '0;
                        state_q       <= S_GAP;
                    end else begin
                        scan_q <= scan_q + 1'b1;
                    end
                end
                S_GAP: begin
                end
                S_DUMP: begin
                    if (!wd_valid_q) begin
                        wd_valid_q <= 1'b1;
                    end else if (wd_ready) begin
                        if (wd_addr_q == LAST_WORD) begin
                            wd_valid_q       <= 1'b0;
                            wd_addr_q        <= '0;
                            done_q           <= 1'b1;
                            busy_q           <= 1'b0;
                            core_event_vec_q <= '0;
                            state_q          <= S_DONE;
                        end else begin
                            wd_addr_q <= wd_addr_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // End-of-step decision shared by SPKOUT (no learning) and GAP.
            if (step_end_d) begin
                if (more_steps_d) begin
                    t_q       <= t_inc_d;
                    ev_addr_q <= t_inc_d[EAW-1:0];
                    ev_rd_q   <= 1'b1;
                    state_q   <= S_FETCH;
                end else if (dump_q) begin
                    wd_addr_q  <= '0;
                    wd_valid_q <= 1'b0;
                    state_q    <= S_DUMP;
                end else begin
                    done_q           <= 1'b1;
                    busy_q           <= 1'b0;
                    core_event_vec_q <= '0;
                    state_q          <= S_DONE;
                end
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign ev_addr        = ev_addr_q;
    assign ev_rd          = ev_rd_q;
    assign core_event_vec = core_event_vec_q;
    assign stdp_enable    = stdp_enable_q;
    assign stdp_pre_bits  = stdp_pre_q;
    assign stdp_post_bits = stdp_post_q;
    assign spk_valid      = spk_valid_q;
    assign spk_data       = spk_data_q;
    assign spk_step       = spk_step_q;
    assign rb_addr        = rb_addr_d;
    assign wd_valid       = wd_valid_q;
    assign wd_addr        = wd_addr_q;
    assign wd_data        = wd_valid_q ? $signed(rb_data) : 16'sd0;

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed bench for snn_step_scheduler with small models of the event memory,
// the core spike path and the core weight readback.
module tb_snn_step_scheduler;

    localparam int F        = 48;
    localparam int N        = 96;
    localparam int AW       = 13;
    localparam int EAW      = 16;
    localparam int CORE_LAT = 1;
    localparam int FN       = F * N;

    logic               clk = 1'b0;
    logic               rstn;
    logic               start;
    logic [15:0]        num_steps;
    logic               learn_en;
    logic               dump_en;
    logic               busy;
    logic               done;
    logic [EAW-1:0]     ev_addr;
    logic               ev_rd;
    logic [F-1:0]       ev_data = '0;
    logic [F-1:0]       core_event_vec;
    logic [N-1:0]       core_spikes_vec = '0;
    logic               stdp_enable;
    logic [F-1:0]       stdp_pre_bits;
    logic [N-1:0]       stdp_post_bits;
    logic               spk_valid;
    logic               spk_ready;
    logic [N-1:0]       spk_data;
    logic [15:0]        spk_step;
    logic [AW-1:0]      rb_addr;
    logic [15:0]        rb_data = '0;
    logic               wd_valid;
    logic               wd_ready;
    logic [AW-1:0]      wd_addr;
    logic signed [15:0] wd_data;

    always #5 clk = ~clk;

    snn_step_scheduler #(
        .F(F), .N(N), .AW(AW), .EAW(EAW), .CORE_LAT(CORE_LAT)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_steps(num_steps),
        .learn_en(learn_en), .dump_en(dump_en), .busy(busy), .done(done),
        .ev_addr(ev_addr), .ev_rd(ev_rd), .ev_data(ev_data),
        .core_event_vec(core_event_vec), .core_spikes_vec(core_spikes_vec),
        .stdp_enable(stdp_enable), .stdp_pre_bits(stdp_pre_bits),
        .stdp_post_bits(stdp_post_bits), .spk_valid(spk_valid),
        .spk_ready(spk_ready), .spk_data(spk_data), .spk_step(spk_step),
        .rb_addr(rb_addr), .rb_data(rb_data), .wd_valid(wd_valid),
        .wd_ready(wd_ready), .wd_addr(wd_addr), .wd_data(wd_data)
    );

    // Event memory contents: step a carries a single event bit a mod F.
    function automatic logic [F-1:0] ev_fn(input int a);
        logic [F-1:0] one;
        one = 1;
        return one << (a % F);
    endfunction

    // Core stand-in: spikes are a fixed function of the applied events.
    function automatic logic [N-1:0] core_fn(input logic [F-1:0] e);
        return {e ^ 48'h0000_FFFF_0000, ~e};
    endfunction

    function automatic logic [15:0] w_fn(input int a);
        return 16'hC000 + 16'(a);
    endfunction

    always @(posedge clk) begin
        if (ev_rd) ev_data <= ev_fn(int'(ev_addr));
        core_spikes_vec <= core_fn(core_event_vec);
        rb_data <= w_fn(int'(rb_addr));
    end

    // Monitor: samples on the falling edge and records transactions.
    int          cyc = 0;
    int          ev_rd_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          en_total = 0;
    int          en_len = 0;
    int          pre_bad = 0;
    int          viol_cnt = 0;
    int          hs_step = 0;
    int          wd_cnt = 0;
    int          wd_exp_addr = 0;
    int          wd_addr_bad = 0;
    int          wd_data_bad = 0;
    int          wd_last_cyc = 0;
    int          wd_last_addr = 0;
    logic [15:0] wd_first = '0;
    int          spk_steps[$];
    logic [N-1:0] spk_datas[$];
    int          spk_cycs[$];
    int          ev_addrs[$];
    int          ev_cycs[$];
    int          en_runs[$];
    int          en_falls[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ev_rd) begin
            ev_rd_cnt <= ev_rd_cnt + 1;
            ev_addrs.push_back(int'(ev_addr));
            ev_cycs.push_back(cyc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (spk_valid && spk_ready) begin
            spk_steps.push_back(int'(spk_step));
            spk_datas.push_back(spk_data);
            spk_cycs.push_back(cyc);
            hs_step <= int'(spk_step);
        end
        if (stdp_enable) begin
            en_total <= en_total + 1;
            en_len   <= en_len + 1;
            if (stdp_pre_bits != ev_fn(hs_step) || stdp_post_bits != core_fn(ev_fn(hs_step)))
                pre_bad <= pre_bad + 1;
        end else if (en_len != 0) begin
            en_runs.push_back(en_len);
            en_falls.push_back(cyc);
            en_len <= 0;
        end
        if (spk_valid && (stdp_enable || stdp_pre_bits != '0 || stdp_post_bits != '0))
            viol_cnt <= viol_cnt + 1;
        if (wd_valid && wd_ready) begin
            if (int'(wd_addr) != wd_exp_addr) wd_addr_bad <= wd_addr_bad + 1;
            if (wd_data != $signed(w_fn(wd_exp_addr))) wd_data_bad <= wd_data_bad + 1;
            if (wd_cnt == 0) wd_first <= wd_data;
            wd_exp_addr  <= wd_exp_addr + 1;
            wd_cnt       <= wd_cnt + 1;
            wd_last_cyc  <= cyc;
            wd_last_addr <= int'(wd_addr);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: 0x%0h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_start(input logic [15:0] steps, input logic le, input logic de);
        num_steps = steps;
        learn_en  = le;
        dump_en   = de;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < budget) begin
            tick(1);
            i++;
        end
        chk(tag, done_cnt - d0, 1);
    endtask

    initial begin : main
        int sb;
        int eb;
        int rb;
        int fb;
        int db;
        int evb;
        int enb;
        int i;
        int ws;

        rstn = 1'b0; start = 1'b0; num_steps = '0; learn_en = 1'b0; dump_en = 1'b0;
        spk_ready = 1'b1; wd_ready = 1'b0;
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ctrl", {ev_rd, stdp_enable, spk_valid, wd_valid}, 0);
        chk("rst_vecs", {ev_addr, core_event_vec, spk_data, spk_step, rb_addr, wd_addr}, 0);
        chk("rst_wd_data", wd_data, 0);
        rstn = 1'b1;
        tick(2);

        // Inference run, with a start pulse during the run that must be ignored.
        sb = spk_steps.size(); evb = ev_rd_cnt; enb = en_total;
        run_start(16'd3, 1'b0, 1'b0);
        chk("inf_busy", busy, 1);
        tick(3);
        num_steps = 16'd0; start = 1'b1; tick(1); start = 1'b0;
        wait_done("inf_done", 200);
        chk("inf_beats", spk_steps.size() - sb, 3);
        for (int k = 0; k < 3 && sb + k < spk_steps.size(); k++) begin
            chk($sformatf("inf_step%0d", k), spk_steps[sb + k], k);
            chk($sformatf("inf_data%0d", k), spk_datas[sb + k], core_fn(ev_fn(k)));
            if (k > 0) chk($sformatf("inf_space%0d", k), spk_cycs[sb + k] - spk_cycs[sb + k - 1], 4 + CORE_LAT);
        end
        chk("inf_ev_rd", ev_rd_cnt - evb, 3);
        chk("inf_no_stdp", en_total - enb, 0);
        chk("inf_busy_end", busy, 0);
        db = done_cnt;
        tick(6);
        chk("inf_single_done", done_cnt - db, 0);
        chk("inf_evec_cleared", core_event_vec, 0);

        // Zero-step run.
        evb = ev_rd_cnt;
        num_steps = 16'd0; start = 1'b1; tick(1); start = 1'b0;
        chk("t0_done", done, 1);
        chk("t0_busy", busy, 0);
        tick(1);
        chk("t0_done_pulse", done, 0);
        chk("t0_no_ev_rd", ev_rd_cnt - evb, 0);

        // Spike backpressure on step 0.
        spk_ready = 1'b0;
        sb = spk_steps.size(); evb = ev_rd_cnt;
        run_start(16'd2, 1'b0, 1'b0);
        i = 0;
        while (!spk_valid && i < 50) begin tick(1); i++; end
        chk("bp_valid", spk_valid, 1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_data%0d", k), spk_data, core_fn(ev_fn(0)));
            chk($sformatf("bp_step%0d", k), spk_step, 0);
            chk($sformatf("bp_no_ev_rd%0d", k), ev_rd_cnt - evb, 1);
            tick(1);
        end
        spk_ready = 1'b1;
        wait_done("bp_done", 200);
        chk("bp_beats", spk_steps.size() - sb, 2);
        if (spk_steps.size() - sb == 2) begin
            chk("bp_step1", spk_steps[sb + 1], 1);
            chk("bp_data1", spk_datas[sb + 1], core_fn(ev_fn(1)));
        end

        // Learning scan.
        sb = spk_steps.size(); rb = en_runs.size(); eb = ev_cycs.size(); fb = pre_bad;
        run_start(16'd2, 1'b1, 1'b0);
        i = 0;
        while (!stdp_enable && i < 50) begin tick(1); i++; end
        chk("ln_enable", stdp_enable, 1);
        chk("ln_pre0", stdp_pre_bits, ev_fn(0));
        chk("ln_post0", stdp_post_bits, core_fn(ev_fn(0)));
        wait_done("ln_done", 12000);
        chk("ln_runs", en_runs.size() - rb, 2);
        if (en_runs.size() - rb == 2) begin
            chk("ln_len0", en_runs[rb], FN);
            chk("ln_len1", en_runs[rb + 1], FN);
            chk("ln_done_after_gap", done_cyc, en_falls[rb + 1] + 1);
            if (ev_cycs.size() - eb == 2) chk("ln_gap0", ev_cycs[eb + 1], en_falls[rb] + 1);
        end
        if (spk_steps.size() - sb == 2) chk("ln_step_space", spk_cycs[sb + 1] - spk_cycs[sb], 4 + CORE_LAT + FN + 1);
        chk("ln_prepost_bad", pre_bad - fb, 0);
        chk("ln_no_overlap", viol_cnt, 0);

        // Weight dump with wd_ready toggling.
        run_start(16'd1, 1'b0, 1'b1);
        db = done_cnt; i = 0;
        while (done_cnt == db && i < 20000) begin
            wd_ready = ~wd_ready;
            tick(1);
            i++;
        end
        chk("wd_done", done_cnt - db, 1);
        wd_ready = 1'b0;
        chk("wd_beats", wd_cnt, FN);
        chk("wd_addr_seq", wd_addr_bad, 0);
        chk("wd_data_match", wd_data_bad, 0);
        chk("wd_last_addr", wd_last_addr, FN - 1);
        ws = $signed(wd_first);
        chk("wd_sign", ws, -16384);
        chk("wd_done_timing", done_cyc, wd_last_cyc + 1);

        // Reset in the middle of the step-2 scan.
        sb = spk_steps.size();
        run_start(16'd3, 1'b1, 1'b0);
        i = 0;
        while (spk_steps.size() - sb < 3 && i < 20000) begin tick(1); i++; end
        chk("rr_reached_step2", spk_steps.size() - sb, 3);
        tick(100);
        chk("rr_in_learn", stdp_enable, 1);
        db = done_cnt;
        rstn = 1'b0;
        #1;
        chk("rr_busy", busy, 0);
        chk("rr_ctrl", {stdp_enable, spk_valid, ev_rd, wd_valid, done}, 0);
        chk("rr_vecs", {stdp_pre_bits, stdp_post_bits, core_event_vec, ev_addr, spk_step}, 0);
        tick(3);
        rstn = 1'b1;
        tick(3);
        chk("rr_no_done", done_cnt - db, 0);
        sb = spk_steps.size(); eb = ev_addrs.size();
        run_start(16'd1, 1'b0, 1'b0);
        wait_done("rr_rerun_done", 200);
        if (spk_steps.size() - sb == 1) chk("rr_rerun_step", spk_steps[sb], 0);
        else chk("rr_rerun_beats", spk_steps.size() - sb, 1);
        if (ev_addrs.size() - eb == 1) chk("rr_rerun_addr", ev_addrs[eb], 0);
        else chk("rr_rerun_reads", ev_addrs.size() - eb, 1);

        // Long run spot-check: address follows t, then abort with reset.
        eb = ev_addrs.size();
        run_start(16'hFFFF, 1'b0, 1'b0);
        tick(30);
        for (int k = 0; k < 5; k++)
            chk($sformatf("long_ev_addr%0d", k), (eb + k < ev_addrs.size()) ? ev_addrs[eb + k] : -1, k);
        chk("long_busy", busy, 1);
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
        chk("long_abort_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
